instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//  Inverse of the controller decode: packs mnemonic index + operand fields into 32-bit instruction
//  words using the core's opcode/func map, and writes them sequentially into instruction memory.
//  Feeds the imem write port from the bench/boot loader; the core then fetches what was written.
//  On finish, seals the program with a halt word (j to its own address).
// PARAMETERS
//  ADDR_W  8    imem word-address width
//  DEPTH   256  program capacity in words (2..2^ADDR_W), including the halt slot
//  BASE    0    word address of the first instruction
// PORTS
//  clk        in   1       clock
//  rst        in   1       async reset, active-high
//  clr        in   1       sync restart: count<=0, err cleared, state<=IDLE
//  in_valid   in   1       request valid
//  in_ready   out  1       request accepted when in_valid&&in_ready
//  in_mnem    in   5       mnemonic index (table below)
//  in_rs/rt/rd in  5 each  register fields
//  in_shamt   in   5       shift amount (used by sll/srl/sra only)
//  in_imm     in   16      immediate (I-type)
//  in_target  in   26      jump target (J-type)
//  finish     in   1       pulse: write halt word, enter DONE
//  imem_we    out  1       imem write strobe (registered)
//  imem_addr  out  ADDR_W  word address = (BASE+count) mod 2^ADDR_W
//  imem_wdata out  32      encoded word
//  count      out  ADDR_W+1  words written so far
//  done       out  1       program sealed
//  err        out  1       sticky: invalid mnemonic seen
//  err_cnt    out  8       invalid requests dropped (saturates at 255)
// BEHAVIOUR
//  Reset: imem_we=0, imem_addr=BASE, imem_wdata=0, count=0, done=0, err=0, err_cnt=0, state IDLE.
//  Mnemonic map. R-type {6'h00,rs,rt,rd,shamt,func}, func hex: 0 add 20, 1 addu 21, 2 sub 22,
//   3 subu 23, 4 and 24, 5 or 25, 6 xor 26, 7 nor 27, 8 slt 2A, 9 sltu 2B, 10 sll 00, 11 srl 02,
//   12 sra 03, 13 sllv 04, 14 srlv 06, 15 srav 07, 16 jr 08, 17 jalr 09.
//  I-type {op,rs,rt,imm}, op hex: 18 addi 08, 19 slti 0A, 20 sltiu 0B, 21 lw 17, 22 sw 2B,
//   23 beq 04, 24 bne 05, 25 ori 0D, 26 xori 0F, 27 andi 01, 28 lui 07.
//  J-type {op,target}: 29 j 02, 30 jal 03. Index 31 is invalid.
//  Field forcing: shamt=0 for all except 10-12; rs=0 for 10-12 and lui; rt=rd=0 for jr.
//  States: IDLE (count==0) -> RUN on first accept -> FULL when count==DEPTH-1 -> DONE on finish.
//   in_ready = (state IDLE|RUN) && !pend_halt. FULL/DONE: in_ready=0.
//  Latency: accept in cycle N -> imem_we=1 with addr/data in N+1; count increments in N+1.
//   Back-to-back accepts give one write per cycle, consecutive addresses.
//  Invalid mnemonic: accepted (handshake completes), no write, count unchanged, err<=1,
//   err_cnt+=1 (saturating).
//  finish in IDLE/RUN/FULL: next cycle writes {6'h02, 26'(BASE+count)} at BASE+count, count+=1,
//   done<=1, state DONE. finish in DONE ignored. The last slot is reserved, so the halt word
//   always fits.
//  finish together with an accepted request: the instruction is written first (N+1), the halt word
//   next (N+2); in_ready=0 from N+1.
//  imem_we is a 1-cycle pulse per word; imem_addr/imem_wdata hold their last values otherwise.
//  imem_addr wraps modulo 2^ADDR_W when BASE+DEPTH exceeds it.
//  clr has priority over all requests and finish; a write registered in the same cycle is dropped.
//  rst mid-operation: immediate return to reset values; a pending halt is discarded.
// TESTING
//  addi rs=1 rt=2 imm=0x0005 -> one cycle later: we=1, addr=0, wdata=0x20220005, count=1.
//  add rs=1 rt=2 rd=3 shamt=7, then lw rs=3 rt=4 imm=8 back-to-back -> 0x00221820 @0,
//   0x5C640008 @1 (shamt forced 0), one write per cycle.
//  mnem=31, then sll rt=2 rd=5 shamt=4 rs=9 -> no write for the first, err=1, err_cnt=1;
//   second writes 0x00022900 @0.
//  DEPTH=4: three valid accepts -> in_ready=0 after the third; finish -> 0x08000003 @3, done=1.
//  finish with accept of j target=0x10 at count=2 -> 0x08000010 @2, then 0x08000003 @3.
//  Assert rst and clr mid-stream -> all outputs return to reset values, next accept writes at BASE.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: packs a mnemonic index plus operand fields into 32-bit
// instruction words and streams them into instruction memory, one word per
// accepted request. A finish pulse seals the program with a self-jump halt
// word in the slot after the last instruction.
module instr_encoder #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int BASE   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_mnem,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              finish,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              err,
  output logic [7:0]        err_cnt
);

  localparam int CW = ADDR_W + 1;

  // Controller states: IDLE holds only while nothing has been written,
  // FULL means only the reserved halt slot remains.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FULL = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [ADDR_W-1:0] BASE_ADDR    = ADDR_W'(BASE);
  localparam logic [25:0]       BASE_TGT     = 26'(BASE);
  localparam logic [CW-1:0]     CNT_LAST     = CW'(DEPTH - 1);
  localparam logic [CW-1:0]     CNT_ONE      = CW'(1);
  localparam logic [4:0]        MNEM_INVALID = 5'd31;
  localparam logic [5:0]        OP_J         = 6'h02;

  // R-type func code (mnemonics 0..17) or I/J-type opcode (18..30).
  function automatic logic [5:0] code_of(input logic [4:0] mnem);
    logic [5:0] c;
    c = 6'h00;
    case (mnem)
      5'd0:  c = 6'h20;  // add
      5'd1:  c = 6'h21;  // addu
      5'd2:  c = 6'h22;  // sub
      5'd3:  c = 6'h23;  // subu
      5'd4:  c = 6'h24;  // and
      5'd5:  c = 6'h25;  // or
      5'd6:  c = 6'h26;  // xor
      5'd7:  c = 6'h27;  // nor
      5'd8:  c = 6'h2A;  // slt
      5'd9:  c = 6'h2B;  // sltu
      5'd10: c = 6'h00;  // sll
      5'd11: c = 6'h02;  // srl
      5'd12: c = 6'h03;  // sra
      5'd13: c = 6'h04;  // sllv
      5'd14: c = 6'h06;  // srlv
      5'd15: c = 6'h07;  // srav
      5'd16: c = 6'h08;  // jr
      5'd17: c = 6'h09;  // jalr
      5'd18: c = 6'h08;  // addi
      5'd19: c = 6'h0A;  // slti
      5'd20: c = 6'h0B;  // sltiu
      5'd21: c = 6'h17;  // lw
      5'd22: c = 6'h2B;  // sw
      5'd23: c = 6'h04;  // beq
      5'd24: c = 6'h05;  // bne
      5'd25: c = 6'h0D;  // ori
      5'd26: c = 6'h0F;  // xori
      5'd27: c = 6'h01;  // andi
      5'd28: c = 6'h07;  // lui
      5'd29: c = 6'h02;  // j
      5'd30: c = 6'h03;  // jal
      default: c = 6'h00;
    endcase
    return c;
  endfunction

  // Full instruction word with unused fields forced to zero so the decoder
  // never sees stray bits (shamt outside shifts, rs on immediate shifts/lui,
  // rt/rd on jr).
  function automatic logic [31:0] encode(
    input logic [4:0]  mnem,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  shamt,
    input logic [15:0] imm,
    input logic [25:0] tgt
  );
    logic [5:0]  code;
    logic [4:0]  rs_f;
    logic [4:0]  rt_f;
    logic [4:0]  rd_f;
    logic [4:0]  sh_f;
    logic [31:0] w;
    code = code_of(mnem);
    rs_f = rs;
    rt_f = rt;
    rd_f = rd;
    sh_f = 5'd0;
    if (mnem == 5'd10 || mnem == 5'd11 || mnem == 5'd12) begin
      sh_f = shamt;
      rs_f = 5'd0;
    end
    if (mnem == 5'd16) begin
      rt_f = 5'd0;
      rd_f = 5'd0;
    end
    if (mnem == 5'd28) begin
      rs_f = 5'd0;
    end
    if (mnem < 5'd18) begin
      w = {6'h00, rs_f, rt_f, rd_f, sh_f, code};
    end else if (mnem < 5'd29) begin
      w = {code, rs_f, rt_f, imm};
    end else begin
      w = {code, tgt};
    end
    return w;
  endfunction

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [7:0]        errcnt_q, errcnt_d;
  logic              pend_q, pend_d;

  logic              ready;
  logic              accept;
  logic              mnem_ok;
  logic [ADDR_W-1:0] slot_addr;
  logic [31:0]       halt_word;
  logic [31:0]       instr_word;
  logic [CW-1:0]     next_count;

  // Handshake and the address/words that a write this cycle would use.
  always_comb begin
    ready      = ((state_q == S_IDLE) || (state_q == S_RUN)) && !pend_q;
    accept     = in_valid && ready;
    mnem_ok    = (in_mnem != MNEM_INVALID);
    slot_addr  = BASE_ADDR + count_q[ADDR_W-1:0];
    halt_word  = {OP_J, BASE_TGT + 26'(count_q)};
    instr_word = encode(in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target);
    next_count = count_q + CNT_ONE;
  end

  // Next-state: clr restart, deferred halt, instruction write, drop/halt.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    done_d   = done_q;
    err_d    = err_q;
    errcnt_d = errcnt_q;
    pend_d   = pend_q;
    if (clr) begin
      state_d  = S_IDLE;
      count_d  = '0;
      addr_d   = BASE_ADDR;
      wdata_d  = 32'd0;
      done_d   = 1'b0;
      err_d    = 1'b0;
      errcnt_d = 8'd0;
      pend_d   = 1'b0;
    end else if (pend_q) begin
      // Halt requested alongside the previous instruction goes in now.
      we_d    = 1'b1;
      addr_d  = slot_addr;
      wdata_d = halt_word;
      count_d = next_count;
      done_d  = 1'b1;
      pend_d  = 1'b0;
      state_d = S_DONE;
    end else if (accept && mnem_ok) begin
      we_d    = 1'b1;
      addr_d  = slot_addr;
      wdata_d = instr_word;
      count_d = next_count;
      state_d = (next_count == CNT_LAST) ? S_FULL : S_RUN;
      pend_d  = finish;
    end else begin
      if (accept) begin
        err_d = 1'b1;
        if (errcnt_q != 8'hFF) begin
          errcnt_d = errcnt_q + 8'd1;
        end
      end
      // No instruction occupies the write slot, so the halt goes in directly.
      if (finish && (state_q != S_DONE)) begin
        we_d    = 1'b1;
        addr_d  = slot_addr;
        wdata_d = halt_word;
        count_d = next_count;
        done_d  = 1'b1;
        state_d = S_DONE;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      we_q     <= 1'b0;
      addr_q   <= BASE_ADDR;
      wdata_q  <= 32'd0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      errcnt_q <= 8'd0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      done_q   <= done_d;
      err_q    <= err_d;
      errcnt_q <= errcnt_d;
      pend_q   <= pend_d;
    end
  end

  assign in_ready   = ready;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_cnt    = errcnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: three encoder instances (large, wrapping, tiny) driven by
// a shared stimulus stream and checked every cycle against a word-level model.
module tb_instr_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clr, in_valid, finish;
  logic [4:0]  in_mnem, in_rs, in_rt, in_rd, in_shamt;
  logic [15:0] in_imm;
  logic [25:0] in_target;

  logic        a_ready, a_we, a_done, a_err;
  logic [7:0]  a_addr, a_errcnt;
  logic [31:0] a_wdata;
  logic [8:0]  a_count;

  logic        b_ready, b_we, b_done, b_err;
  logic [2:0]  b_addr;
  logic [7:0]  b_errcnt;
  logic [31:0] b_wdata;
  logic [3:0]  b_count;

  logic        c_ready, c_we, c_done, c_err;
  logic [7:0]  c_addr, c_errcnt;
  logic [31:0] c_wdata;
  logic [8:0]  c_count;

  instr_encoder #(.ADDR_W(8), .DEPTH(256), .BASE(0)) u_a (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(a_ready),
    .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_imm(in_imm), .in_target(in_target), .finish(finish),
    .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata), .count(a_count),
    .done(a_done), .err(a_err), .err_cnt(a_errcnt));

  instr_encoder #(.ADDR_W(3), .DEPTH(6), .BASE(5)) u_b (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(b_ready),
    .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_imm(in_imm), .in_target(in_target), .finish(finish),
    .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata), .count(b_count),
    .done(b_done), .err(b_err), .err_cnt(b_errcnt));

  instr_encoder #(.ADDR_W(8), .DEPTH(4), .BASE(0)) u_c (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(c_ready),
    .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_imm(in_imm), .in_target(in_target), .finish(finish),
    .imem_we(c_we), .imem_addr(c_addr), .imem_wdata(c_wdata), .count(c_count),
    .done(c_done), .err(c_err), .err_cnt(c_errcnt));

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  // Instance geometry
  int depth_t[3] = '{256, 6, 4};
  int base_t[3]  = '{0, 5, 0};
  int aw_t[3]    = '{8, 3, 8};

  // Mnemonic tables: func for 0..17, opcode for 18..30
  int functab[18] = '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2A,
                      'h2B, 'h00, 'h02, 'h03, 'h04, 'h06, 'h07, 'h08, 'h09};
  int optab[13]   = '{'h08, 'h0A, 'h0B, 'h17, 'h2B, 'h04, 'h05, 'h0D, 'h0F,
                      'h01, 'h07, 'h02, 'h03};

  // Model state per instance
  int        m_cnt[3], m_done[3], m_err[3], m_ecnt[3], m_pend[3], m_we[3], m_addr[3];
  bit [31:0] m_wdata[3];

  function automatic bit [31:0] ref_encode(int m, int rs, int rt, int rd, int sh,
                                           int imm, int tgt);
    bit [31:0] w;
    int rsv, rtv, rdv, shv;
    rsv = rs; rtv = rt; rdv = rd; shv = 0;
    if (m < 18) begin
      if (m >= 10 && m <= 12) begin shv = sh; rsv = 0; end
      if (m == 16) begin rtv = 0; rdv = 0; end
      w = 32'(rsv) * 32'h0020_0000 + 32'(rtv) * 32'h0001_0000 + 32'(rdv) * 32'h800
          + 32'(shv) * 32'h40 + 32'(functab[m]);
    end else if (m < 29) begin
      if (m == 28) rsv = 0;
      w = 32'(optab[m-18]) * 32'h0400_0000 + 32'(rsv) * 32'h0020_0000
          + 32'(rtv) * 32'h0001_0000 + 32'(imm);
    end else begin
      w = 32'(optab[m-18]) * 32'h0400_0000 + 32'(tgt);
    end
    return w;
  endfunction

  task automatic model_reset(input int i);
    m_we[i] = 0; m_addr[i] = base_t[i] % (1 << aw_t[i]); m_wdata[i] = 0;
    m_cnt[i] = 0; m_done[i] = 0; m_err[i] = 0; m_ecnt[i] = 0; m_pend[i] = 0;
  endtask

  function automatic bit m_ready(input int i);
    return (m_done[i] == 0) && (m_pend[i] == 0) && (m_cnt[i] < depth_t[i] - 1);
  endfunction

  task automatic model_write(input int i, input bit [31:0] w);
    m_we[i] = 1;
    m_addr[i] = (base_t[i] + m_cnt[i]) % (1 << aw_t[i]);
    m_wdata[i] = w;
    m_cnt[i] = m_cnt[i] + 1;
  endtask

  task automatic model_halt(input int i);
    bit [31:0] w;
    w = {6'h02, 26'(base_t[i] + m_cnt[i])};
    model_write(i, w);
    m_done[i] = 1;
  endtask

  task automatic model_step(input int i);
    bit acc;
    if (clr) begin
      model_reset(i);
    end else begin
      acc = in_valid && m_ready(i);
      m_we[i] = 0;
      if (m_pend[i] != 0) begin
        m_pend[i] = 0;
        model_halt(i);
      end else if (acc && in_mnem != 5'd31) begin
        model_write(i, ref_encode(int'(in_mnem), int'(in_rs), int'(in_rt), int'(in_rd),
                                  int'(in_shamt), int'(in_imm), int'(in_target)));
        if (finish) m_pend[i] = 1;
      end else begin
        if (acc) begin
          m_err[i] = 1;
          if (m_ecnt[i] < 255) m_ecnt[i] = m_ecnt[i] + 1;
        end
        if (finish && m_done[i] == 0) model_halt(i);
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) model_reset(i);
    end else begin
      for (int i = 0; i < 3; i++) model_step(i);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int i, input logic [63:0] we, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [63:0] cnt,
                          input logic [63:0] dn, input logic [63:0] er,
                          input logic [63:0] ec, input logic [63:0] rdy);
    chk($sformatf("u%0d.we", i), we, 64'(m_we[i]));
    chk($sformatf("u%0d.addr", i), addr, 64'(m_addr[i]));
    chk($sformatf("u%0d.wdata", i), wdata, 64'(m_wdata[i]));
    chk($sformatf("u%0d.count", i), cnt, 64'(m_cnt[i]));
    chk($sformatf("u%0d.done", i), dn, 64'(m_done[i]));
    chk($sformatf("u%0d.err", i), er, 64'(m_err[i]));
    chk($sformatf("u%0d.err_cnt", i), ec, 64'(m_ecnt[i]));
    chk($sformatf("u%0d.in_ready", i), rdy, 64'(m_ready(i)));
  endtask

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      cmp_inst(0, a_we, a_addr, a_wdata, a_count, a_done, a_err, a_errcnt, a_ready);
      cmp_inst(1, b_we, b_addr, b_wdata, b_count, b_done, b_err, b_errcnt, b_ready);
      cmp_inst(2, c_we, c_addr, c_wdata, c_count, c_done, c_err, c_errcnt, c_ready);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; finish = 1'b0; clr = 1'b0;
  endtask

  task automatic req(input int m, input int rs, input int rt, input int rd,
                     input int sh, input int imm, input int tgt);
    in_valid = 1'b1; in_mnem = 5'(m); in_rs = 5'(rs); in_rt = 5'(rt);
    in_rd = 5'(rd); in_shamt = 5'(sh); in_imm = 16'(imm); in_target = 26'(tgt);
  endtask

  task automatic do_clr();
    idle(); clr = 1'b1; tick(); clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; idle(); req(0, 0, 0, 0, 0, 0, 0); in_valid = 1'b0;
    tick();
    cmp_en = 1'b1;
    tick();
    rst = 1'b0;

    // Reset values
    chk("rst.we", a_we, 0);       chk("rst.addr", a_addr, 0);
    chk("rst.wdata", a_wdata, 0); chk("rst.count", a_count, 0);
    chk("rst.done", a_done, 0);   chk("rst.err", a_err, 0);
    chk("rst.err_cnt", a_errcnt, 0); chk("rst.ready", a_ready, 1);
    chk("rst.b_addr", b_addr, 5);

    // addi rs=1 rt=2 imm=5
    req(18, 1, 2, 0, 0, 5, 0); tick(); idle();
    chk("addi.we", a_we, 1); chk("addi.addr", a_addr, 0);
    chk("addi.wdata", a_wdata, 32'h2022_0005); chk("addi.count", a_count, 1);
    tick();
    chk("addi.we_pulse", a_we, 0); chk("addi.wdata_hold", a_wdata, 32'h2022_0005);
    do_clr();
    chk("clr.count", a_count, 0); chk("clr.wdata", a_wdata, 0);

    // add then lw back-to-back
    req(0, 1, 2, 3, 7, 0, 0); tick();
    chk("add.wdata", a_wdata, 32'h0022_1820); chk("add.addr", a_addr, 0);
    req(21, 3, 4, 0, 0, 8, 0); tick(); idle();
    chk("lw.wdata", a_wdata, 32'h5C64_0008); chk("lw.addr", a_addr, 1);
    chk("lw.we", a_we, 1); chk("lw.count", a_count, 2);
    do_clr();

    // invalid mnemonic then sll
    req(31, 1, 2, 3, 4, 'h1234, 0); tick();
    chk("inv.we", a_we, 0); chk("inv.err", a_err, 1);
    chk("inv.err_cnt", a_errcnt, 1); chk("inv.count", a_count, 0);
    req(10, 9, 2, 5, 4, 0, 0); tick(); idle();
    chk("sll.wdata", a_wdata, 32'h0002_2900); chk("sll.addr", a_addr, 0);
    chk("sll.we", a_we, 1);
    do_clr();

    // DEPTH=4 instance fills, then finish
    req(18, 1, 1, 0, 0, 1, 0); tick();
    req(18, 1, 1, 0, 0, 2, 0); tick();
    chk("c.ready_mid", c_ready, 1);
    req(18, 1, 1, 0, 0, 3, 0); tick(); idle();
    chk("c.ready_full", c_ready, 0); chk("c.count_full", c_count, 3);
    finish = 1'b1; tick(); finish = 1'b0;
    chk("c.halt_wdata", c_wdata, 32'h0800_0003); chk("c.halt_addr", c_addr, 3);
    chk("c.done", c_done, 1); chk("c.count_done", c_count, 4);
    do_clr();

    // finish together with j accept at count=2
    req(18, 0, 1, 0, 0, 1, 0); tick();
    req(18, 0, 2, 0, 0, 2, 0); tick();
    req(29, 0, 0, 0, 0, 0, 'h10); finish = 1'b1; tick(); idle();
    chk("j.wdata", a_wdata, 32'h0800_0010); chk("j.addr", a_addr, 2);
    chk("j.ready", a_ready, 0); chk("j.done_early", a_done, 0);
    tick();
    chk("jhalt.wdata", a_wdata, 32'h0800_0003); chk("jhalt.addr", a_addr, 3);
    chk("jhalt.done", a_done, 1); chk("jhalt.we", a_we, 1);
    do_clr();

    // err_cnt saturation
    for (int k = 0; k < 260; k++) begin req(31, 0, 0, 0, 0, 0, 0); tick(); end
    idle();
    chk("sat.err_cnt", a_errcnt, 255); chk("sat.count", a_count, 0);
    do_clr();

    // rst mid-stream with a halt pending
    req(18, 1, 2, 0, 0, 5, 0); tick();
    req(18, 1, 2, 0, 0, 6, 0); finish = 1'b1; tick(); idle();
    rst = 1'b1; #1;
    chk("mrst.we", a_we, 0); chk("mrst.count", a_count, 0);
    chk("mrst.addr", a_addr, 0); chk("mrst.wdata", a_wdata, 0);
    chk("mrst.b_addr", b_addr, 5); chk("mrst.done", a_done, 0);
    tick(); rst = 1'b0;
    tick();
    chk("mrst.no_halt", a_we, 0);
    req(18, 1, 2, 0, 0, 5, 0); tick(); idle();
    chk("mrst.addr2", a_addr, 0); chk("mrst.wdata2", a_wdata, 32'h2022_0005);

    // Random traffic with frequent finish/clr/rst
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 399) == 0);
      in_valid = ($urandom_range(0, 99) < 60);
      in_mnem = 5'($urandom); in_rs = 5'($urandom); in_rt = 5'($urandom);
      in_rd = 5'($urandom); in_shamt = 5'($urandom); in_imm = 16'($urandom);
      in_target = 26'($urandom);
      finish = ($urandom_range(0, 99) < 3);
      clr = ($urandom_range(0, 99) < 2);
      tick();
    end
    rst = 1'b0;
    do_clr();

    // Long runs so the large instance fills to its reserved slot
    for (int c = 0; c < 1500; c++) begin
      in_valid = ($urandom_range(0, 99) < 90);
      in_mnem = 5'($urandom); in_rs = 5'($urandom); in_rt = 5'($urandom);
      in_rd = 5'($urandom); in_shamt = 5'($urandom); in_imm = 16'($urandom);
      in_target = 26'($urandom);
      finish = ($urandom_range(0, 999) == 0) || (c == 700);
      clr = (c == 800);
      tick();
    end
    idle();
    tick(); tick();
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
